mem_access: RTL

//  Memory-stage data-bus request engine, directly upstream of writeback load extraction.
//  - Accepts one load/store per handshake, checks alignment and builds the byte strobe.
//  - Store data is shifted into its byte lanes before the dbus request is issued.
//  - Runs the dbus addr_ok/data_ok handshake.
//  - Holds the raw 64-bit response plus addr[2:0], msize and unsigned until writeback consumes them.

---
 rtl/mem_access.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: memory-stage data-bus request engine.
// Accepts one load/store at a time, checks alignment, builds the byte strobe
// and lane-shifted store data, runs the dbus addr_ok/data_ok handshake and
// holds the raw response until writeback consumes it.
// Optional data_ok watchdog: define MEM_ACCESS_TIMEOUT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new memory op (req_ready=1)
// REQ   | dbus request presented, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// DONE  | result held for writeback until out_ready
module mem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [63:0] req_addr,
   input  logic [1:0]  req_msize,
   input  logic        req_write,
   input  logic        req_unsigned,
   input  logic [63:0] req_wdata,
   output logic        dreq_valid,
   output logic [63:0] dreq_addr,
   output logic [1:0]  dreq_size,
   output logic [7:0]  dreq_strobe,
   output logic [63:0] dreq_data,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok,
   input  logic [63:0] dresp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_rdata,
   output logic [2:0]  out_addr_lo,
   output logic [1:0]  out_msize,
   output logic        out_unsigned,
   output logic        out_is_load,
   output logic        out_misalign,
   output logic        out_bus_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0] state;
   logic [2:0] addr_lo;
   logic [2:0] size_mask;
   logic [7:0] strobe_base;
   logic       misaligned;
   logic       accept;
   logic       capture;
   logic       wd_expire;

   assign addr_lo    = req_addr[2:0];
   assign misaligned = |(addr_lo & size_mask);
   assign accept     = (state == ST_IDLE) && req_valid;
   assign capture    = ((state == ST_REQ) && dresp_addr_ok && dresp_data_ok) ||
                       ((state == ST_WAIT) && dresp_data_ok);

   assign req_ready  = (state == ST_IDLE);
   assign dreq_valid = (state == ST_REQ);
   assign out_valid  = (state == ST_DONE);

   always_comb begin
      size_mask   = 3'b000;
      strobe_base = 8'h01;
      case (req_msize)
         2'd0:    begin size_mask = 3'b000; strobe_base = 8'h01; end
         2'd1:    begin size_mask = 3'b001; strobe_base = 8'h03; end
         2'd2:    begin size_mask = 3'b011; strobe_base = 8'h0F; end
         default: begin size_mask = 3'b111; strobe_base = 8'hFF; end
      endcase
   end

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] wd_cnt;
   logic             bus_err_q;

   assign wd_expire = ((state == ST_REQ) || (state == ST_WAIT)) && !capture &&
                      (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign out_bus_err = bus_err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
      end else if (state == ST_IDLE) begin
         wd_cnt <= '0;
      end else if (state != ST_DONE) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_err_q <= 1'b0;
      end else if (accept) begin
         bus_err_q <= 1'b0;
      end else if (wd_expire) begin
         bus_err_q <= 1'b1;
      end
   end
`else
   assign wd_expire   = 1'b0;
   assign out_bus_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         dreq_addr    <= '0;
         dreq_size    <= '0;
         dreq_strobe  <= '0;
         dreq_data    <= '0;
         out_rdata    <= '0;
         out_addr_lo  <= '0;
         out_msize    <= '0;
         out_unsigned <= 1'b0;
         out_is_load  <= 1'b0;
         out_misalign <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  dreq_addr    <= req_addr;
                  dreq_size    <= req_msize;
                  dreq_strobe  <= req_write ? (strobe_base << addr_lo) : 8'h00;
                  dreq_data    <= req_write ? (req_wdata << {addr_lo, 3'b000}) : 64'h0;
                  out_rdata    <= '0;
                  out_addr_lo  <= addr_lo;
                  out_msize    <= req_msize;
                  out_unsigned <= req_unsigned;
                  out_is_load  <= ~req_write;
                  out_misalign <= misaligned;
                  state        <= misaligned ? ST_DONE : ST_REQ;
               end
            end
            ST_REQ: begin
               if (capture) begin
                  if (out_is_load) out_rdata <= dresp_data;
                  state <= ST_DONE;
               end else if (wd_expire) begin
                  state <= ST_DONE;
               end else if (dresp_addr_ok) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (capture) begin
                  if (out_is_load) out_rdata <= dresp_data;
                  state <= ST_DONE;
               end else if (wd_expire) begin
                  state <= ST_DONE;
               end
            end
            default: begin
               if (out_ready) state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
